// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: accepts one block, then steps the subkey selector
// through 16 rounds (K1..K16 for encrypt, K16..K1 for decrypt) and holds the result.
module des_round_sequencer #(
    parameter int unsigned ROUNDS   = 16,
    parameter int unsigned SEL_W    = 5,
    parameter int unsigned IDLE_SEL = 31
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    output logic                      load_data,
    output logic                      round_en,
    output logic [SEL_W-1:0]          key_sel,
    output logic                      last_round,
    output logic [$clog2(ROUNDS)-1:0] round_cnt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int unsigned       CNT_W   = $clog2(ROUNDS);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(ROUNDS - 1);

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               round_en_d;
    logic [SEL_W-1:0]   key_sel_d;
    logic               last_round_d;
    logic               out_valid_d;
    logic               busy_d;
    logic               accept;

    assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    assign accept    = in_valid & in_ready;
    assign load_data = accept;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        cnt_d        = round_cnt;
        out_valid_d  = out_valid;
        round_en_d   = 1'b0;
        key_sel_d    = SEL_W'(IDLE_SEL);
        last_round_d = 1'b0;

        case (state_q)
            StIdle: ;
            StRound: begin
                if (round_cnt == CNT_MAX) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = round_cnt + CNT_W'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Accept overrides the DONE->IDLE transition for back-to-back jobs.
        if (accept) begin
            state_d = StRound;
            mode_d  = mode;
            cnt_d   = '0;
        end

        // Registered round outputs describe the round that runs in the next cycle.
        if (state_d == StRound) begin
            round_en_d   = 1'b1;
            key_sel_d    = mode_d ? SEL_W'(CNT_MAX - cnt_d) : SEL_W'(cnt_d);
            last_round_d = (cnt_d == CNT_MAX);
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            round_cnt  <= '0;
            round_en   <= 1'b0;
            key_sel    <= SEL_W'(IDLE_SEL);
            last_round <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            round_cnt  <= cnt_d;
            round_en   <= round_en_d;
            key_sel    <= key_sel_d;
            last_round <= last_round_d;
            out_valid  <= out_valid_d;
            busy       <= busy_d;
        end
    end

endmodule
